gen_collector: RTL and testbench

// Caller-side initiator for the generator ready/valid/done protocol. Starts one

---
 rtl/gen_collector.sv | 208 ++++++++++++++++++++
 tb/tb_gen_collector.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_collector.sv
// gen_collector: starts one generator call, drains its yields into a FIFO and
//   keeps a running item count and signed sum of everything accepted.
// Latency: cmd_start -> gen_start next cycle; accepted yield -> rd_valid next cycle.
// Backpressure: gen_ready falls while the FIFO is full; rd_ready pops the head.
//
// Ports:
//   _clock, _reset            rising-edge clock, async active-low reset
//   cmd_start/cmd_abort       call control pulses; cmd_arg0..2 sampled on start
//   gen_start, gen_arg0..2    drive the callee's start strobe and inputs
//   gen_ready/gen_valid/gen_0 yield handshake with the callee, gen_done = finished
//   rd_valid/rd_ready/rd_data FIFO read side (registered head, no fall-through)
//   busy, res_done, res_aborted, res_count, res_sum   call status and results
module gen_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [WIDTH-1:0]   cmd_arg0,
  input  logic [WIDTH-1:0]   cmd_arg1,
  input  logic [WIDTH-1:0]   cmd_arg2,
  output logic               gen_start,
  output logic [WIDTH-1:0]   gen_arg0,
  output logic [WIDTH-1:0]   gen_arg1,
  output logic [WIDTH-1:0]   gen_arg2,
  output logic               gen_ready,
  input  logic               gen_valid,
  input  logic               gen_done,
  input  logic [WIDTH-1:0]   gen_0,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               busy,
  output logic               res_done,
  output logic               res_aborted,
  output logic [31:0]        res_count,
  output logic [2*WIDTH-1:0] res_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_COLLECT = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
  } args_t;

  state_t state_q, state_d;
  args_t  args_q;

  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        occ_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               fifo_full, fifo_empty;

  logic               start_acc;   // cmd_start taken this cycle (also flushes FIFO)
  logic               abort_acc;   // cmd_abort taken this cycle
  logic               finish;      // callee reported done, call ends normally
  logic               xfer;        // yield accepted this cycle
  logic               pop;

  logic [31:0]        count_q;
  logic [2*WIDTH-1:0] sum_q;
  logic               aborted_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Call sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    abort_acc = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          start_acc = 1'b1;
          state_d   = S_START;
        end
      end
      // gen_done/gen_valid are left over from the callee's previous run here,
      // so only an abort can change the course of the call.
      S_START: begin
        if (cmd_abort) begin
          abort_acc = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      // Abort wins over done; done ends the call even with the FIFO full since
      // the callee cannot be holding an item once it reports done.
      S_COLLECT: begin
        if (cmd_abort) begin
          abort_acc = 1'b1;
          state_d   = S_IDLE;
        end else if (gen_done) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gen_start = (state_q == S_START);
  assign gen_ready = (state_q == S_COLLECT) && !fifo_full;
  assign busy      = (state_q != S_IDLE);

  // An item offered in the abort cycle is dropped, not counted.
  assign xfer = gen_ready && gen_valid && !cmd_abort;

  // ---------------------------------------------------------------------------
  // Yield FIFO. The flush on an accepted start takes priority over a pop.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FULL_OCC);
  assign pop        = rd_ready && !fifo_empty && !start_acc;
  assign rd_valid   = !fifo_empty;
  assign rd_data    = mem_q[rd_ptr_q];

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (start_acc) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (xfer) begin
        mem_q[wr_ptr_q] <= gen_0;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // xfer is impossible when full, so occupancy never exceeds DEPTH
      unique case ({xfer, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Arguments and results
  // ---------------------------------------------------------------------------
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      args_q    <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish || abort_acc;
      if (start_acc) begin
        args_q    <= '{a0: cmd_arg0, a1: cmd_arg1, a2: cmd_arg2};
        count_q   <= '0;
        sum_q     <= '0;
        aborted_q <= 1'b0;
      end else begin
        if (xfer) begin
          count_q <= count_q + 32'd1;
          sum_q   <= sum_q + (2*WIDTH)'($signed(gen_0));
        end
        if (abort_acc) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  assign gen_arg0    = args_q.a0;
  assign gen_arg1    = args_q.a1;
  assign gen_arg2    = args_q.a2;
  assign res_done    = done_q;
  assign res_aborted = aborted_q;
  assign res_count   = count_q;
  assign res_sum     = sum_q;

endmodule

// File: tb/tb_gen_collector.sv
// tb_gen_collector: drives gen_collector against a behavioural range/dup_range
//   callee, with scoreboarded FIFO output and table, random and corner cases.
module tb_gen_collector;

  localparam int W = 32;
  localparam int D = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [W-1:0]   cmd_arg0 = '0, cmd_arg1 = '0, cmd_arg2 = '0;
  logic           gen_start, gen_ready, gen_valid, gen_done;
  logic [W-1:0]   gen_arg0, gen_arg1, gen_arg2, gen_0;
  logic           rd_ready = 1'b0;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic           busy, res_done, res_aborted;
  logic [31:0]    res_count;
  logic [2*W-1:0] res_sum;

  always #5 clock = ~clock;

  gen_collector #(.WIDTH(W), .DEPTH(D)) dut (
    ._clock(clock), ._reset(reset_n),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .gen_start(gen_start), .gen_arg0(gen_arg0), .gen_arg1(gen_arg1), .gen_arg2(gen_arg2),
    .gen_ready(gen_ready), .gen_valid(gen_valid), .gen_done(gen_done), .gen_0(gen_0),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .res_done(res_done), .res_aborted(res_aborted),
    .res_count(res_count), .res_sum(res_sum)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Generator sequences in plain arithmetic: range(a,b,s) = a, a+s, ... < b;
  // dup_range yields every range element twice.
  function automatic longint range_len(input longint a, input longint b, input longint s);
    if (s <= 0 || b <= a) return 0;
    return (b - a + s - 1) / s;
  endfunction

  function automatic longint seq_len(input int mode, input longint a, input longint b, input longint s);
    return (mode == 1) ? 2 * range_len(a, b, s) : range_len(a, b, s);
  endfunction

  function automatic longint seq_item(input int mode, input longint a, input longint s, input longint i);
    return (mode == 1) ? a + (i / 2) * s : a + i * s;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural callee: first yield two cycles after its start strobe, done
  // held high whenever it is idle or exhausted, optional random valid stalls.
  // ---------------------------------------------------------------------------
  int     callee_mode = 0;
  logic   stall_en = 1'b0;
  logic   c_busy = 1'b0;
  logic   c_stall = 1'b0;
  int     c_wait = 0;
  int     c_mode = 0;
  longint c_idx = 0, c_a = 0, c_b = 0, c_s = 1;

  assign gen_valid = c_busy && (c_wait == 0) && (c_idx < seq_len(c_mode, c_a, c_b, c_s)) && !c_stall;
  assign gen_done  = !c_busy || ((c_wait == 0) && (c_idx >= seq_len(c_mode, c_a, c_b, c_s)));
  assign gen_0     = W'(seq_item(c_mode, c_a, c_s, c_idx));

  always @(posedge clock) begin
    c_stall <= stall_en && ($urandom_range(0, 3) == 0);
    if (gen_start) begin
      c_busy <= 1'b1;
      c_wait <= 1;
      c_idx  <= 0;
      c_mode <= callee_mode;
      c_a    <= longint'($signed(gen_arg0));
      c_b    <= longint'($signed(gen_arg1));
      c_s    <= longint'($signed(gen_arg2));
    end else if (c_busy) begin
      if (c_wait > 0) c_wait <= c_wait - 1;
      else if (gen_ready && gen_valid) c_idx <= c_idx + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-side scoreboard: every pop must match the next expected item.
  // ---------------------------------------------------------------------------
  logic   mon_en = 1'b0;
  logic   saw_valid = 1'b0;
  longint exp_q[$];

  always @(negedge clock) begin : monitor
    longint e;
    if (mon_en) begin
      if (rd_valid) saw_valid = 1'b1;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected_item", longint'($signed(rd_data)), -1);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", longint'($signed(rd_data)), e);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_exp(input int mode, input longint a0, input longint a1, input longint a2);
    exp_q.delete();
    for (longint i = 0; i < seq_len(mode, a0, a1, a2); i++) exp_q.push_back(seq_item(mode, a0, a2, i));
  endtask

  task automatic start_call(input int mode, input longint a0, input longint a1, input longint a2);
    callee_mode = mode;
    cmd_arg0 = W'(a0);
    cmd_arg1 = W'(a1);
    cmd_arg2 = W'(a2);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  // n = clock edges from the cmd_start edge up to the first res_done cycle
  task automatic wait_done(input string tag, input bit rnd, output bit ok, output int n);
    ok = 1'b0;
    n  = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      n++;
      if (rnd) rd_ready = ($urandom_range(0, 1) == 1);
      if (res_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout({tag, "_res_done"});
  endtask

  task automatic wait_count(input string tag, input longint target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (longint'(res_count) == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout({tag, "_count"});
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) fail_timeout({tag, "_drain"});
    chk({tag, "_empty_after_drain"}, longint'(rd_valid), 0);
  endtask

  task automatic run_vec(input string tag, input int mode, input longint a0, input longint a1,
                         input longint a2, input bit rnd, input longint cnt, input longint sum);
    bit ok;
    int n;
    saw_valid = 1'b0;
    stall_en  = rnd;
    rd_ready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    load_exp(mode, a0, a1, a2);
    mon_en = 1'b1;
    start_call(mode, a0, a1, a2);
    chk({tag, "_gen_start"}, longint'(gen_start), 1);
    chk({tag, "_gen_arg1"}, longint'($signed(gen_arg1)), a1);
    wait_done(tag, rnd, ok, n);
    if (ok) begin
      if (cnt == 0) chk({tag, "_empty_done_within_4"}, longint'(n <= 4), 1);
      chk({tag, "_count"}, longint'(res_count), cnt);
      chk({tag, "_sum"}, longint'($signed(res_sum)), sum);
      chk({tag, "_aborted"}, longint'(res_aborted), 0);
      chk({tag, "_busy_after_done"}, longint'(busy), 0);
      tick();
      chk({tag, "_done_single_pulse"}, longint'(res_done), 0);
    end
    drain(tag);
    if (cnt == 0) chk({tag, "_rd_valid_never"}, longint'(saw_valid), 0);
    mon_en   = 1'b0;
    stall_en = 1'b0;
  endtask

  typedef struct {
    int     mode;
    longint a0, a1, a2;
    bit     rnd;
    longint cnt, sum;
  } vec_t;

  vec_t   vecs[9];
  bit     ok;
  int     m;
  longint ra, rb, rs, rc, rsum;

  initial begin
    vecs[0] = '{0, 0, 10, 2, 0, 5, 20};
    vecs[1] = '{0, 5, 5, 1, 0, 0, 0};
    vecs[2] = '{0, -4, 4, 3, 0, 3, -3};
    vecs[3] = '{1, 1, 4, 1, 0, 6, 12};
    vecs[4] = '{0, 10, 0, 1, 0, 0, 0};
    vecs[5] = '{1, -5, -1, 2, 0, 4, -16};
    vecs[6] = '{0, 0, 20, 1, 1, 20, 190};
    vecs[7] = '{0, 64'sh7FFFFFF0, 64'sh7FFFFFFF, 5, 1, 3, 64'sh17FFFFFDF};
    vecs[8] = '{0, -64'sd2147483648, -64'sd2147483645, 1, 0, 3, -64'sd6442450941};

    // reset state, no clock edge needed
    #12;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rd_valid", longint'(rd_valid), 0);
    chk("rst_rd_data", longint'(rd_data), 0);
    chk("rst_gen_start", longint'(gen_start), 0);
    chk("rst_gen_ready", longint'(gen_ready), 0);
    chk("rst_res_done", longint'(res_done), 0);
    chk("rst_res_aborted", longint'(res_aborted), 0);
    chk("rst_res_count", longint'(res_count), 0);
    chk("rst_res_sum", longint'(res_sum), 0);
    chk("rst_gen_arg0", longint'(gen_arg0), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].mode, vecs[v].a0, vecs[v].a1, vecs[v].a2,
              vecs[v].rnd, vecs[v].cnt, vecs[v].sum);
    end

    // backpressure: dup_range(0,6,2) with the reader stalled
    rd_ready = 1'b0;
    load_exp(1, 0, 6, 2);
    mon_en = 1'b1;
    start_call(1, 0, 6, 2);
    wait_count("bp", 4, ok);
    tick(); tick(); tick();
    chk("bp_gen_ready_low", longint'(gen_ready), 0);
    chk("bp_count_held", longint'(res_count), 4);
    chk("bp_busy", longint'(busy), 1);
    chk("bp_head", longint'($signed(rd_data)), 0);
    rd_ready = 1'b1;
    wait_done("bp", 1'b0, ok, m);
    chk("bp_count", longint'(res_count), 6);
    chk("bp_sum", longint'($signed(res_sum)), 12);
    drain("bp");
    mon_en = 1'b0;

    // abort after three items; FIFO keeps exactly 0,1,2
    rd_ready = 1'b0;
    start_call(0, 0, 100, 1);
    wait_count("abort", 3, ok);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_done_pulse", longint'(res_done), 1);
    chk("abort_aborted", longint'(res_aborted), 1);
    chk("abort_count", longint'(res_count), 3);
    chk("abort_sum", longint'($signed(res_sum)), 3);
    chk("abort_busy", longint'(busy), 0);
    tick();
    chk("abort_done_single", longint'(res_done), 0);
    chk("abort_aborted_held", longint'(res_aborted), 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_fifo_valid%0d", i), longint'(rd_valid), 1);
      chk($sformatf("abort_fifo_item%0d", i), longint'($signed(rd_data)), i);
      tick();
    end
    chk("abort_fifo_empty", longint'(rd_valid), 0);

    // leftovers from an aborted call are flushed by the next start
    rd_ready = 1'b0;
    start_call(0, 0, 100, 1);
    wait_count("flush", 2, ok);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("flush_leftover_valid", longint'(rd_valid), 1);
    load_exp(0, -3, 0, 1);
    start_call(0, -3, 0, 1);
    chk("flush_empty", longint'(rd_valid), 0);
    chk("flush_aborted_cleared", longint'(res_aborted), 0);
    rd_ready = 1'b1;
    mon_en = 1'b1;
    wait_done("flush", 1'b0, ok, m);
    chk("flush_count", longint'(res_count), 3);
    chk("flush_sum", longint'($signed(res_sum)), -6);
    drain("flush");
    mon_en = 1'b0;

    // randomized calls against the arithmetic model
    for (int r = 0; r < 12; r++) begin
      m    = int'($urandom_range(0, 1));
      ra   = longint'($urandom_range(0, 100)) - 50;
      rb   = ra + longint'($urandom_range(0, 30));
      rs   = longint'($urandom_range(1, 4));
      rc   = seq_len(m, ra, rb, rs);
      rsum = 0;
      for (longint i = 0; i < rc; i++) rsum += seq_item(m, ra, rs, i);
      run_vec($sformatf("rnd%0d", r), m, ra, rb, rs, 1'b1, rc, rsum);
    end

    // cmd_start while busy is ignored
    rd_ready = 1'b1;
    start_call(0, 0, 100, 1);
    tick(); tick(); tick();
    cmd_arg0  = 32'd77;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    chk("busy_start_arg0", longint'($signed(gen_arg0)), 0);
    chk("busy_start_no_gen_start", longint'(gen_start), 0);
    chk("busy_start_busy", longint'(busy), 1);

    // async reset mid-COLLECT, checked before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_rd_valid", longint'(rd_valid), 0);
    chk("arst_gen_start", longint'(gen_start), 0);
    chk("arst_gen_ready", longint'(gen_ready), 0);
    chk("arst_res_count", longint'(res_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("arst_idle_after_release", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
